// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, memory-wait freeze with timeout.
// Optional macro PIPE_HAZARD_PERF_CNT_EN builds a saturating stall-cycle counter on stall_cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] idex_regD,
  input  logic             idex_is_load,
  input  logic             exmem_mux_sel,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             pc_sel,
  output logic             mem_err,
  output logic [31:0]      stall_cycles
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic             r_br_pend, w_br_pend_nxt;
  logic             w_load_use;

  assign w_load_use = idex_is_load && (idex_regD != '0) &&
                      ((id_rs1_used && (id_rs1 == idex_regD)) ||
                       (id_rs2_used && (id_rs2 == idex_regD)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_to_cnt  <= '0;
      r_br_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_br_pend <= w_br_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_br_pend_nxt = r_br_pend;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    memwb_flush   = 1'b0;
    pc_sel        = 1'b0;
    mem_err       = 1'b0;

    case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          // Whole pipe frozen; a branch seen now is replayed when memory completes
          memwb_flush   = 1'b1;
          w_state_nxt   = MEM_WAIT;
          w_to_cnt_nxt  = CNT_W'(1);
          w_br_pend_nxt = exmem_mux_sel;
        end else if (exmem_mux_sel) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          pc_sel     = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end

      MEM_WAIT: begin
        if (!mem_ready) begin
          memwb_flush = 1'b1;
          if (r_to_cnt == CNT_W'(MEM_TIMEOUT)) begin
            w_state_nxt = MEM_ERR;
          end else if (r_to_cnt != '1) begin
            w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
          end
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          if (r_br_pend) begin
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end
          w_br_pend_nxt = 1'b0;
          w_to_cnt_nxt  = '0;
          w_state_nxt   = RUN;
        end
      end

      MEM_ERR: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
        mem_err     = 1'b1;
      end

      default: begin
        w_state_nxt = RUN;
      end
    endcase

    // Reset overrides every control output
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      pc_sel      = 1'b0;
      mem_err     = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default parameters).
module tb_pipe_hazard_ctrl;

  // {pc_en,ifid_en,idex_en,exmem_en,memwb_en,ifid_flush,idex_flush,memwb_flush,pc_sel,mem_err}
  localparam logic [9:0] V_RST = 10'b00000_000_0_0;
  localparam logic [9:0] V_RUN = 10'b11111_000_0_0;
  localparam logic [9:0] V_HAZ = 10'b00111_010_0_0;
  localparam logic [9:0] V_BR  = 10'b11111_110_1_0;
  localparam logic [9:0] V_FRZ = 10'b00000_001_0_0;
  localparam logic [9:0] V_ERR = 10'b00000_111_0_1;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, idex_regD;
  logic        id_rs1_used, id_rs2_used, idex_is_load;
  logic        exmem_mux_sel, mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush, pc_sel, mem_err;
  logic [31:0] stall_cycles;
  logic [9:0]  w_obs;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned stall_model;

  pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .idex_regD    (idex_regD),
    .idex_is_load (idex_is_load),
    .exmem_mux_sel(exmem_mux_sel),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_flush  (memwb_flush),
    .pc_sel       (pc_sel),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  assign w_obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_flush, pc_sel, mem_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; idex_regD = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; idex_is_load = 1'b0;
    exmem_mux_sel = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Compares control outputs and the stall counter; the model counts cycles with pc_en low
  task automatic chk(input string tag, input logic [9:0] exp);
    logic [31:0] exp_sc;
    n_checks++;
    assert (w_obs === exp) else begin
      n_errors++;
      $error("FAIL %s: ctrl observed %b expected %b", tag, w_obs, exp);
    end
`ifdef PIPE_HAZARD_PERF_CNT_EN
    exp_sc = 32'(stall_model);
`else
    exp_sc = 32'd0;
`endif
    n_checks++;
    assert (stall_cycles === exp_sc) else begin
      n_errors++;
      $error("FAIL %s_stall: stall_cycles observed %0d expected %0d", tag, stall_cycles, exp_sc);
    end
    if (!exp[9] && !reset) stall_model++;
  endtask

  initial begin
    logic [31:0] exp4;
    n_checks = 0; n_errors = 0; stall_model = 0;
    idle();
    reset = 1'b1;
    exmem_mux_sel = 1'b1; mem_req = 1'b1;
    #1 chk("reset_hold", V_RST);

    @(negedge clk); reset = 1'b0; idle();
    #1 chk("run_idle", V_RUN);

    // Load x3 in EX, ID reads x3 on rs1
    @(negedge clk); idex_is_load = 1'b1; idex_regD = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    #1 chk("lu_rs1", V_HAZ);
    @(negedge clk); idex_is_load = 1'b0;
    #1 chk("lu_after", V_RUN);

    // Memory wait of 3 frozen cycles with a branch at entry, then ready replays the branch
    @(negedge clk); idle(); mem_req = 1'b1; exmem_mux_sel = 1'b1;
    #1 chk("mw_entry", V_FRZ);
    @(negedge clk); exmem_mux_sel = 1'b0;
    #1 chk("mw_wait1", V_FRZ);
    @(negedge clk);
    #1 chk("mw_wait2", V_FRZ);
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("mw_ready_br", V_BR);
    @(negedge clk); idle();
    #1 chk("mw_back_run", V_RUN);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    exp4 = 32'd4;
`else
    exp4 = 32'd0;
`endif
    n_checks++;
    assert (stall_cycles === exp4) else begin
      n_errors++;
      $error("FAIL stall4: stall_cycles observed %0d expected %0d", stall_cycles, exp4);
    end

    // x0 is never a hazard
    @(negedge clk); idex_is_load = 1'b1; idex_regD = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1 chk("lu_x0", V_RUN);
    // Match on unused rs1 only
    @(negedge clk); idex_regD = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b0; id_rs2 = 5'd2; id_rs2_used = 1'b1;
    #1 chk("lu_unused", V_RUN);
    // rs2 match
    @(negedge clk); id_rs2 = 5'd5;
    #1 chk("lu_rs2", V_HAZ);
    // Same match but not a load
    @(negedge clk); idex_is_load = 1'b0;
    #1 chk("lu_notload", V_RUN);
    // Branch wins over load-use
    @(negedge clk); idex_is_load = 1'b1; exmem_mux_sel = 1'b1;
    #1 chk("br_over_lu", V_BR);
    // Memory answers immediately: no stall
    @(negedge clk); idle(); mem_req = 1'b1; mem_ready = 1'b1;
    #1 chk("mem_fast", V_RUN);

    // Wait without a branch: ready must not redirect the PC
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("mw2_entry", V_FRZ);
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("mw2_ready", V_RUN);

    // Timeout: entry plus 16 wait cycles, then terminal error
    @(negedge clk); idle(); mem_req = 1'b1;
    #1 chk("to_entry", V_FRZ);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      #1 chk($sformatf("to_wait%0d", i), V_FRZ);
    end
    @(negedge clk);
    #1 chk("to_err", V_ERR);
    @(negedge clk); mem_ready = 1'b1; exmem_mux_sel = 1'b1;
    #1 chk("err_sticky1", V_ERR);
    @(negedge clk); mem_req = 1'b0;
    #1 chk("err_sticky2", V_ERR);

    // Asynchronous reset out of MEM_ERR
    #1 reset = 1'b1; stall_model = 0;
    #1 chk("err_reset", V_RST);
    @(negedge clk); reset = 1'b0; idle();
    #1 chk("err_to_run", V_RUN);

    // Reset mid-wait clears the pending branch
    @(negedge clk); mem_req = 1'b1; exmem_mux_sel = 1'b1;
    #1 chk("rw_entry", V_FRZ);
    @(negedge clk); exmem_mux_sel = 1'b0;
    #1 chk("rw_wait", V_FRZ);
    #1 reset = 1'b1; stall_model = 0;
    #1 chk("rw_reset", V_RST);
    @(negedge clk); reset = 1'b0; idle();
    #1 chk("rw_run", V_RUN);
    @(negedge clk); mem_req = 1'b1;
    #1 chk("rw_entry2", V_FRZ);
    @(negedge clk); mem_ready = 1'b1;
    #1 chk("rw_nopend", V_RUN);

    @(negedge clk); idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL provide parameter MEM_TIMEOUT, default 16, max MEM_WAIT cycles before error (legal range 2..255).
REQ-003 SHALL provide clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL provide reset  in  1  asynchronous, active-high.
REQ-005 SHALL provide id_rs1, id_rs2  in  REG_W each  source specifiers of the instruction in ID.
REQ-006 SHALL provide id_rs1_used, id_rs2_used  in  1 each  qualify id_rs1/id_rs2.
REQ-007 SHALL provide idex_regD  in  REG_W  destination of the instruction in EX.
REQ-008 SHALL provide idex_is_load  in  1  instruction in EX is a load.
REQ-009 SHALL provide exmem_mux_sel  in  1  taken branch resolved in Mem, target valid on EX/Mem target bus.
REQ-010 SHALL provide mem_req  in  1  Mem stage requests data memory this cycle.
REQ-011 SHALL provide mem_ready  in  1  data memory completes the request this cycle.
REQ-012 SHALL provide pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
REQ-013 SHALL provide ifid_flush, idex_flush, memwb_flush  out  1 each  load a no-op into that register on the next edge.
REQ-014 SHALL provide pc_sel  out  1  1 = PC loads branch target.
REQ-015 SHALL provide mem_err  out  1  sticky memory-timeout flag.
REQ-016 SHALL provide stall_cycles  out  32  stall counter (see Configuration).

Function
REQ-017 SHALL implement states RUN, MEM_WAIT, MEM_ERR; all outputs combinational from state, registered flags and current inputs.
REQ-018 Load-use hazard SHALL be: idex_is_load and idex_regD!=0 and ((id_rs1_used and id_rs1==idex_regD) or (id_rs2_used and id_rs2==idex_regD)).
REQ-019 In RUN with no event, all enables SHALL be 1, all flushes 0, pc_sel 0.
REQ-020 In RUN on load-use hazard only: pc_en=0, ifid_en=0, idex_flush=1, other enables 1; one bubble per hazard, zero added latency otherwise.
REQ-021 In RUN on exmem_mux_sel=1: pc_sel=1, ifid_flush=1, idex_flush=1, all enables 1; the delay-slot instruction in EX SHALL proceed.
REQ-022 Branch and load-use in the same cycle: branch behaviour (REQ-021) SHALL win; no stall.
REQ-023 In RUN with mem_req=1 and mem_ready=0: all enables 0, memwb_flush=1, branch effects suppressed; next state MEM_WAIT, timeout counter loaded with 1.
REQ-024 If exmem_mux_sel=1 when entering MEM_WAIT, a branch_pending flag SHALL be set.
REQ-025 In MEM_WAIT with mem_ready=0: same outputs as REQ-023; counter increments; at counter==MEM_TIMEOUT next state MEM_ERR.
REQ-026 In MEM_WAIT with mem_ready=1: all enables 1, memwb_flush=0; if branch_pending, apply REQ-021 outputs and clear flag; next state RUN.
REQ-027 mem_req=1 with mem_ready=1 in RUN SHALL cause no stall.
REQ-028 MEM_ERR SHALL be terminal until reset: all enables 0, all flushes 1, mem_err=1, pc_sel 0.
REQ-029 Counter SHALL saturate and never wrap; inputs ignored in MEM_ERR.

Reset
REQ-030 Asserting reset SHALL immediately force state RUN, branch_pending 0, timeout counter 0, mem_err 0, stall_cycles 0, including mid-MEM_WAIT.
REQ-031 While reset is high, all enables, flushes and pc_sel SHALL be 0.

Configuration
REQ-032 With PIPE_HAZARD_PERF_CNT_EN defined, stall_cycles SHALL increment by 1 each cycle pc_en=0 outside reset, saturating at 0xFFFFFFFF.
REQ-033 Without PIPE_HAZARD_PERF_CNT_EN, stall_cycles SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-034 Load x3 in EX, ID reads rs1=3 used -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
REQ-035 idex_regD=0 with load, id_rs1=0 used -> no stall.
REQ-036 exmem_mux_sel=1 alongside load-use -> pc_sel=1, ifid_flush=1, idex_flush=1, pc_en=1.
REQ-037 mem_req=1, mem_ready low 3 cycles, branch taken at entry -> 3 frozen cycles with memwb_flush=1; on ready cycle pc_sel=1 and flushes; state RUN.
REQ-038 mem_ready never asserted, MEM_TIMEOUT=16 -> MEM_ERR after 16 MEM_WAIT cycles, mem_err=1 held; reset clears to RUN.
REQ-039 With PIPE_HAZARD_PERF_CNT_EN: one load-use stall plus 3-cycle mem wait -> stall_cycles=4; without macro -> 0.
